// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: programmable DEPTH-symbol sequence detector.
// Symbols of SYM_W bits shift into a history window. A registered one-cycle pulse
// on Q flags that the window matches the stored pattern. match_cnt counts matches
// and saturates at its maximum value.
// Optional feature macro: SEQ_DONTCARE_EN adds a per-entry don't-care mask that is
// loaded through pat_mask.
//
// Handshake: a symbol is consumed on a rising edge when in_valid=1 and pat_load=0.
// pat_load=1 always wins. The write goes to the pattern store, and the symbol
// presented in that cycle is dropped.
module seq_detect_fsm #(
    parameter  int SYM_W  = 2,
    parameter  int DEPTH  = 4,
    parameter  int CNT_W  = 8,
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] sym,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [IDX_W-1:0] pat_idx,
    input  logic [SYM_W-1:0] pat_sym,
`ifdef SEQ_DONTCARE_EN
    input  logic [SYM_W-1:0] pat_mask,
`endif
    output logic             Q,
    output logic [CNT_W-1:0] match_cnt,
    output logic [FILL_W-1:0] fill
);

    // Occupancy regions of the history window. These are derived from r_fill, which is the state.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_ARMED   = 2'd2
    } state_t;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

    // Registered state
    logic [SYM_W-1:0]  r_hist [DEPTH];
    logic [SYM_W-1:0]  r_pat  [DEPTH];
    logic [FILL_W-1:0] r_fill;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_q;

    // Next-state values
    logic [SYM_W-1:0]  w_hist_next [DEPTH];
    logic [SYM_W-1:0]  w_pat_next  [DEPTH];
    logic [FILL_W-1:0] w_fill_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_q_next;

    // Helper signals
    state_t            w_state;
    logic [SYM_W-1:0]  w_hist_shift [DEPTH];
    logic [SYM_W-1:0]  w_cmp_mask   [DEPTH];
    logic [FILL_W-1:0] w_fill_inc;
    logic              w_all_eq;
    logic              w_accept;
    logic              w_match;
    logic              w_idx_ok;

`ifdef SEQ_DONTCARE_EN
    logic [SYM_W-1:0]  r_mask      [DEPTH];
    logic [SYM_W-1:0]  w_mask_next [DEPTH];
`endif

    // Classify the current fill level into a region
    always_comb begin
        w_state = ST_FILLING;
        if (r_fill == '0) begin
            w_state = ST_EMPTY;
        end else if (r_fill == FILL_FULL) begin
            w_state = ST_ARMED;
        end
    end

    // Shifted history. The oldest symbol drops out of position 0, and the newest enters at DEPTH-1.
    always_comb begin
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_hist_shift[k] = r_hist[k + 1];
        end
        w_hist_shift[DEPTH-1] = sym;
    end

    // Per-entry compare mask. A bit set to 1 here takes part in the comparison.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
`ifdef SEQ_DONTCARE_EN
            w_cmp_mask[k] = ~r_mask[k];
`else
            w_cmp_mask[k] = '1;
`endif
        end
    end

    // Compare the post-shift history against the pattern, entry by entry
    always_comb begin
        w_all_eq = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (((w_hist_shift[k] ^ r_pat[k]) & w_cmp_mask[k]) != '0) begin
                w_all_eq = 1'b0;
            end
        end
    end

    // Fill after accepting one symbol. It saturates once the window is armed.
    always_comb begin
        w_fill_inc = r_fill + 1'b1;
        case (w_state)
            ST_ARMED: w_fill_inc = r_fill;
            default:  w_fill_inc = r_fill + 1'b1;
        endcase
    end

    // Accept, match and pattern-write qualifiers
    always_comb begin
        w_accept = in_valid && !pat_load;
        w_match  = w_accept && (w_fill_inc == FILL_FULL) && w_all_eq;
        w_idx_ok = ({1'b0, pat_idx} < (IDX_W + 1)'(DEPTH));
    end

    // Next-state logic for history, fill, counter, pulse and pattern
    always_comb begin
        w_hist_next = r_hist;
        w_pat_next  = r_pat;
        w_fill_next = r_fill;
        w_cnt_next  = r_cnt;
        w_q_next    = 1'b0;
`ifdef SEQ_DONTCARE_EN
        w_mask_next = r_mask;
`endif
        if (pat_load) begin
            // Changing the pattern restarts detection from an empty window
            if (w_idx_ok) begin
                w_pat_next[pat_idx] = pat_sym;
`ifdef SEQ_DONTCARE_EN
                w_mask_next[pat_idx] = pat_mask;
`endif
            end
            w_fill_next = '0;
            for (int k = 0; k < DEPTH; k++) begin
                w_hist_next[k] = '0;
            end
        end else if (w_accept) begin
            w_hist_next = w_hist_shift;
            w_fill_next = w_fill_inc;
            if (w_match) begin
                w_q_next = 1'b1;
                if (r_cnt != '1) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                if (!overlap) begin
                    // Non-overlapping mode: the next match needs a full fresh window
                    w_fill_next = '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        w_hist_next[k] = '0;
                    end
                end
            end
        end
    end

    // State registers. Pattern entry i resets to i modulo 2^SYM_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill <= '0;
            r_cnt  <= '0;
            r_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
                r_pat[i]  <= SYM_W'(i);
            end
        end else begin
            r_fill <= w_fill_next;
            r_cnt  <= w_cnt_next;
            r_q    <= w_q_next;
            r_hist <= w_hist_next;
            r_pat  <= w_pat_next;
        end
    end

`ifdef SEQ_DONTCARE_EN
    // Don't-care mask registers. They reset to all-zero, so every bit is compared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mask[i] <= '0;
            end
        end else begin
            r_mask <= w_mask_next;
        end
    end
`endif

    assign Q         = r_q;
    assign match_cnt = r_cnt;
    assign fill      = r_fill;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb_seq_detect_fsm: table-driven checks of seq_detect_fsm with default parameters.
// A second instance with CNT_W=2 covers counter saturation.
module tb_seq_detect_fsm;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (defaults) ----------------
    logic       in_valid = 1'b0;
    logic [1:0] sym      = '0;
    logic       overlap  = 1'b0;
    logic       pat_load = 1'b0;
    logic [1:0] pat_idx  = '0;
    logic [1:0] pat_sym  = '0;
    logic [1:0] pat_mask = '0;
    logic       q0;
    logic [7:0] cnt0;
    logic [2:0] fill0;

    seq_detect_fsm u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .sym       (sym),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_idx   (pat_idx),
        .pat_sym   (pat_sym),
`ifdef SEQ_DONTCARE_EN
        .pat_mask  (pat_mask),
`endif
        .Q         (q0),
        .match_cnt (cnt0),
        .fill      (fill0)
    );

    // ---------------- DUT 1 (CNT_W=2) ----------------
    logic       v1 = 1'b0;
    logic [1:0] s1 = '0;
    logic       ov1 = 1'b0;
    logic       pl1 = 1'b0;
    logic [1:0] pi1 = '0;
    logic [1:0] ps1 = '0;
    logic [1:0] pm1 = '0;
    logic       q1;
    logic [1:0] cnt1;
    logic [2:0] fill1;

    seq_detect_fsm #(.SYM_W(2), .DEPTH(4), .CNT_W(2)) u_dut_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v1),
        .sym       (s1),
        .overlap   (ov1),
        .pat_load  (pl1),
        .pat_idx   (pi1),
        .pat_sym   (ps1),
`ifdef SEQ_DONTCARE_EN
        .pat_mask  (pm1),
`endif
        .Q         (q1),
        .match_cnt (cnt1),
        .fill      (fill1)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       v;
        logic [1:0] s;
        logic       ov;
        logic       pl;
        logic [1:0] pi;
        logic [1:0] ps;
        logic [1:0] pm;
        logic       eq;
        logic [7:0] ec;
        logic [2:0] ef;
    } vec_t;

    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void add(input logic v, input logic [1:0] s, input logic ov,
                                input logic pl, input logic [1:0] pi, input logic [1:0] ps,
                                input logic eq, input int ec, input int ef);
        vec_t t;
        t.v = v; t.s = s; t.ov = ov; t.pl = pl; t.pi = pi; t.ps = ps; t.pm = 2'b00;
        t.eq = eq; t.ec = 8'(ec); t.ef = 3'(ef);
        tbl.push_back(t);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply0(input vec_t t, input string tag);
        @(negedge clk);
        in_valid = t.v; sym = t.s; overlap = t.ov;
        pat_load = t.pl; pat_idx = t.pi; pat_sym = t.ps; pat_mask = t.pm;
        @(posedge clk);
        #1;
        chk({tag, " Q"},    int'(q0),    int'(t.eq));
        chk({tag, " cnt"},  int'(cnt0),  int'(t.ec));
        chk({tag, " fill"}, int'(fill0), int'(t.ef));
    endtask

    task automatic apply1(input logic [1:0] s, input logic eq, input int ec, input int ef,
                          input string tag);
        @(negedge clk);
        v1 = 1'b1; s1 = s;
        @(posedge clk);
        #1;
        chk({tag, " Q"},    int'(q1),    int'(eq));
        chk({tag, " cnt"},  int'(cnt1),  ec);
        chk({tag, " fill"}, int'(fill1), ef);
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t t;

        // Default pattern 00,01,10,11 with overlap=1
        add(1, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 0, 2);
        add(1, 2, 1, 0, 0, 0, 0, 0, 3);
        add(1, 3, 1, 0, 0, 0, 1, 1, 4);
        add(0, 0, 1, 0, 0, 0, 0, 1, 4);
        // Load pattern 01,01,01,01
        for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 2'(i), 1, 0, 1, 0);
        // Six 01 symbols in overlapping mode
        add(1, 1, 1, 0, 0, 0, 0, 1, 1);
        add(1, 1, 1, 0, 0, 0, 0, 1, 2);
        add(1, 1, 1, 0, 0, 0, 0, 1, 3);
        add(1, 1, 1, 0, 0, 0, 1, 2, 4);
        add(1, 1, 1, 0, 0, 0, 1, 3, 4);
        add(1, 1, 1, 0, 0, 0, 1, 4, 4);
        // Clear the window by rewriting entry 0, then eight 01 symbols in non-overlapping mode
        add(0, 0, 0, 1, 0, 1, 0, 4, 0);
        add(1, 1, 0, 0, 0, 0, 0, 4, 1);
        add(1, 1, 0, 0, 0, 0, 0, 4, 2);
        add(1, 1, 0, 0, 0, 0, 0, 4, 3);
        add(1, 1, 0, 0, 0, 0, 1, 5, 0);
        add(1, 1, 0, 0, 0, 0, 0, 5, 1);
        add(1, 1, 0, 0, 0, 0, 0, 5, 2);
        add(1, 1, 0, 0, 0, 0, 0, 5, 3);
        add(1, 1, 0, 0, 0, 0, 1, 6, 0);
        // Restore the default pattern
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 2'(i), 2'(i), 0, 6, 0);
        // A valid gap holds fill
        add(1, 0, 0, 0, 0, 0, 0, 6, 1);
        add(1, 1, 0, 0, 0, 0, 0, 6, 2);
        for (int i = 0; i < 3; i++) add(0, 3, 0, 0, 0, 0, 0, 6, 2);
        add(1, 2, 0, 0, 0, 0, 0, 6, 3);
        add(1, 3, 0, 0, 0, 0, 1, 7, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7, 0);
        // pat_load wins over in_valid and discards the symbol
        add(1, 0, 0, 0, 0, 0, 0, 7, 1);
        add(1, 1, 0, 0, 0, 0, 0, 7, 2);
        add(1, 2, 0, 0, 0, 0, 0, 7, 3);
        add(1, 3, 0, 1, 0, 0, 0, 7, 0);
        // Restart from an empty window. The armed window mismatches first, then matches.
        add(1, 3, 0, 0, 0, 0, 0, 7, 1);
        add(1, 0, 0, 0, 0, 0, 0, 7, 2);
        add(1, 1, 0, 0, 0, 0, 0, 7, 3);
        add(1, 2, 0, 0, 0, 0, 0, 7, 4);
        add(1, 3, 0, 0, 0, 0, 1, 8, 0);
        // Change entry 0 to 11, then reach fill=3 before the reset
        add(0, 0, 0, 1, 0, 3, 0, 8, 0);
        add(1, 3, 0, 0, 0, 0, 0, 8, 1);
        add(1, 1, 0, 0, 0, 0, 0, 8, 2);
        add(1, 2, 0, 0, 0, 0, 0, 8, 3);

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset Q",    int'(q0),    0);
        chk("reset cnt",  int'(cnt0),  0);
        chk("reset fill", int'(fill0), 0);
        chk("reset sat cnt", int'(cnt1), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply0(tbl[i], $sformatf("vec%0d", i));
        end

        // Assert reset mid-cycle at fill=3. The outputs must clear before any clock edge.
        @(negedge clk);
        in_valid = 1'b0; pat_load = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async Q",    int'(q0),    0);
        chk("async cnt",  int'(cnt0),  0);
        chk("async fill", int'(fill0), 0);
        @(negedge clk);
        reset = 1'b1;
        // After reset, entry 0 must be 00 again
        t = '{v:1, s:0, ov:0, pl:0, pi:0, ps:0, pm:0, eq:0, ec:0, ef:1}; apply0(t, "post0");
        t.s = 1; t.ef = 2;                                       apply0(t, "post1");
        t.s = 2; t.ef = 3;                                       apply0(t, "post2");
        t.s = 3; t.ef = 0; t.eq = 1; t.ec = 1;                   apply0(t, "post3");
        t.v = 0; t.eq = 0;                                       apply0(t, "post4");

`ifdef SEQ_DONTCARE_EN
        // Mask entry 3 fully, so 00,01,10,00 matches
        t = '{v:0, s:0, ov:0, pl:1, pi:3, ps:3, pm:3, eq:0, ec:1, ef:0}; apply0(t, "mask_ld");
        t = '{v:1, s:0, ov:0, pl:0, pi:0, ps:0, pm:0, eq:0, ec:1, ef:1}; apply0(t, "mask0");
        t.s = 1; t.ef = 2;                                       apply0(t, "mask1");
        t.s = 2; t.ef = 3;                                       apply0(t, "mask2");
        t.s = 0; t.ef = 0; t.eq = 1; t.ec = 2;                   apply0(t, "mask3");
`endif

        // Saturating 2-bit counter. Five default-pattern sequences with overlap=0 are sent.
        for (int r = 0; r < 5; r++) begin
            apply1(2'd0, 1'b0, (r < 3) ? r : 3, 1, $sformatf("sat%0d_a", r));
            apply1(2'd1, 1'b0, (r < 3) ? r : 3, 2, $sformatf("sat%0d_b", r));
            apply1(2'd2, 1'b0, (r < 3) ? r : 3, 3, $sformatf("sat%0d_c", r));
            apply1(2'd3, 1'b1, (r < 2) ? r + 1 : 3, 0, $sformatf("sat%0d_d", r));
        end
        @(negedge clk);
        v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("sat idle Q", int'(q1), 0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
